// File: rtl/uart_other_team_adapter.sv
// Bridge between 21-bit ADS request frames and the partner team's byte-wide UART.
// TX splits one frame into four bytes; RX folds two received bytes into one response.
module uart_other_team_adapter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clk_50m,
  input  logic [20:0] tx_frame_in,
  input  logic        tx_frame_valid,
  output logic        tx_frame_ready,
  output logic [7:0]  tx_uart_data_in,
  output logic        tx_uart_wr_en,
  input  logic        tx_uart_tx_busy,
  input  logic [7:0]  rx_uart_data_out,
  input  logic        rx_uart_ready,
  output logic        rx_uart_ready_clr,
  output logic [7:0]  rx_frame_out,
  output logic        rx_frame_valid,
  input  logic        rx_frame_ready
);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_STROBE,
    TX_GUARD,
    TX_WAITB
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_B0,
    RX_B0_REL,
    RX_B1,
    RX_B1_REL,
    RX_OUT
  } rx_state_e;

  // The integrator ties this pin to clk; it only exists for footprint compatibility.
  logic unused_clk_50m;
  assign unused_clk_50m = clk_50m;

  // Byte order on the wire: data, addr low, addr high nibble, mode bit.
  function automatic logic [7:0] tx_byte_sel(input logic [20:0] frame,
                                             input logic [1:0]  idx);
    case (idx)
      2'd0:    return frame[7:0];
      2'd1:    return frame[15:8];
      2'd2:    return {4'h0, frame[19:16]};
      default: return {7'h0, frame[20]};
    endcase
  endfunction

  // ---------------------------------------------------------------- TX path
  tx_state_e   tx_state, tx_state_nxt;
  logic [1:0]  tx_idx_q, tx_idx_nxt;
  logic [20:0] tx_frame_q;
  logic [20:0] tx_byte_src;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_idx_nxt   = tx_idx_q;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_frame_valid) begin
          tx_state_nxt = TX_LOAD;
          tx_idx_nxt   = 2'd0;
        end
      end
      TX_LOAD: begin
        if (!tx_uart_tx_busy) tx_state_nxt = TX_STROBE;
      end
      TX_STROBE: tx_state_nxt = TX_GUARD;
      TX_GUARD:  tx_state_nxt = TX_WAITB;
      TX_WAITB: begin
        if (!tx_uart_tx_busy) begin
          if (tx_idx_q == 2'd3) begin
            tx_state_nxt = TX_IDLE;
          end else begin
            tx_state_nxt = TX_LOAD;
            tx_idx_nxt   = tx_idx_q + 2'd1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Byte 0 is loaded in the accept cycle, before the frame register holds it.
  assign tx_byte_src = (tx_state == TX_IDLE) ? tx_frame_in : tx_frame_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_idx_q <= 2'd0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_idx_q <= tx_idx_nxt;
    end
  end

  // NOTE: the frame register is reset as well, so an aborted frame leaves nothing stale behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_frame_q      <= '0;
      tx_frame_ready  <= 1'b1;
      tx_uart_wr_en   <= 1'b0;
      tx_uart_data_in <= 8'h00;
    end else begin
      if (tx_state == TX_IDLE && tx_frame_valid) tx_frame_q <= tx_frame_in;
      tx_frame_ready <= (tx_state_nxt == TX_IDLE);
      tx_uart_wr_en  <= (tx_state_nxt == TX_STROBE);
      if (tx_state_nxt == TX_LOAD && tx_state != TX_LOAD)
        tx_uart_data_in <= tx_byte_sel(tx_byte_src, tx_idx_nxt);
    end
  end

  // ---------------------------------------------------------------- RX path
  rx_state_e rx_state, rx_state_nxt;
  logic [7:0] rx_data_q;

  // The REL states wait for ready to drop so a long-held byte is taken once.
  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      RX_B0:     if (rx_uart_ready)  rx_state_nxt = RX_B0_REL;
      RX_B0_REL: if (!rx_uart_ready) rx_state_nxt = RX_B1;
      RX_B1:     if (rx_uart_ready)  rx_state_nxt = RX_B1_REL;
      RX_B1_REL: if (!rx_uart_ready) rx_state_nxt = RX_OUT;
      RX_OUT:    if (rx_frame_ready) rx_state_nxt = RX_B0;
      default:   rx_state_nxt = RX_B0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= RX_B0;
    else       rx_state <= rx_state_nxt;
  end

  // The flags byte is only acknowledged: reads and write acks deliver identically.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data_q         <= 8'h00;
      rx_uart_ready_clr <= 1'b0;
      rx_frame_out      <= 8'h00;
      rx_frame_valid    <= 1'b0;
    end else begin
      if (rx_state == RX_B0 && rx_uart_ready) rx_data_q <= rx_uart_data_out;
      rx_uart_ready_clr <= rx_uart_ready &&
                           (rx_state == RX_B0 || rx_state == RX_B1);
      if (rx_state == RX_B1_REL && !rx_uart_ready) rx_frame_out <= rx_data_q;
      rx_frame_valid <= (rx_state_nxt == RX_OUT);
    end
  end

endmodule

// File: tb/tb_uart_other_team_adapter.sv
// Self-checking bench: byte/frame scoreboards built from the frame format rules,
// with directed latency checks and randomized concurrent TX/RX traffic.
`timescale 1ns/1ps
module tb_uart_other_team_adapter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clk_50m;
  logic [20:0] tx_frame_in;
  logic        tx_frame_valid;
  logic        tx_frame_ready;
  logic [7:0]  tx_uart_data_in;
  logic        tx_uart_wr_en;
  logic        tx_uart_tx_busy;
  logic [7:0]  rx_uart_data_out;
  logic        rx_uart_ready;
  logic        rx_uart_ready_clr;
  logic [7:0]  rx_frame_out;
  logic        rx_frame_valid;
  logic        rx_frame_ready;

  logic busy_model, busy_force;
  int   busy_fixed;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_clr = 0;
  int   rx_bytes_sent = 0;
  bit   rx_done;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  assign clk_50m         = clk;
  assign tx_uart_tx_busy = busy_model | busy_force;

  always #10 clk = ~clk;

  uart_other_team_adapter dut (
    .clk              (clk),
    .rstn             (rstn),
    .clk_50m          (clk_50m),
    .tx_frame_in      (tx_frame_in),
    .tx_frame_valid   (tx_frame_valid),
    .tx_frame_ready   (tx_frame_ready),
    .tx_uart_data_in  (tx_uart_data_in),
    .tx_uart_wr_en    (tx_uart_wr_en),
    .tx_uart_tx_busy  (tx_uart_tx_busy),
    .rx_uart_data_out (rx_uart_data_out),
    .rx_uart_ready    (rx_uart_ready),
    .rx_uart_ready_clr(rx_uart_ready_clr),
    .rx_frame_out     (rx_frame_out),
    .rx_frame_valid   (rx_frame_valid),
    .rx_frame_ready   (rx_frame_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which byte goes out in which position, from the frame fields.
  function automatic logic [7:0] model_byte(input logic [20:0] f, input int i);
    int mode, addr, data;
    mode = int'(f[20]);
    addr = int'(f[19:8]);
    data = int'(f[7:0]);
    case (i)
      0:       return 8'(data);
      1:       return 8'(addr % 256);
      2:       return 8'(addr / 256);
      default: return 8'(mode);
    endcase
  endfunction

  // Transmitter model: busy rises after each strobe and stays up for a while.
  initial begin
    int len;
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && tx_uart_wr_en) begin
        len = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 6));
        @(posedge clk); #1 busy_model = 1'b1;
        repeat (len) @(posedge clk);
        #1 busy_model = 1'b0;
      end
    end
  end

  // Compare process: every strobe and every accepted frame against the scoreboards.
  initial begin
    logic prev_wr, prev_clr;
    prev_wr  = 1'b0;
    prev_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (tx_uart_wr_en) begin
          check("tx_wr_width", prev_wr, 1'b0);
          check("tx_wr_while_busy", tx_uart_tx_busy, 1'b0);
          if (tx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_unexpected_strobe: byte=%0h required no strobe at %0t",
                     tx_uart_data_in, $time);
          end else begin
            check("tx_byte", tx_uart_data_in, tx_q.pop_front());
          end
        end
        if (rx_uart_ready_clr) begin
          n_clr++;
          check("rx_clr_width", prev_clr, 1'b0);
        end
        if (rx_frame_valid && rx_frame_ready) begin
          if (rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected_frame: out=%0h required no frame at %0t",
                     rx_frame_out, $time);
          end else begin
            check("rx_frame_out", rx_frame_out, rx_q.pop_front());
          end
        end
      end
      prev_wr  = tx_uart_wr_en;
      prev_clr = rx_uart_ready_clr;
    end
  end

  task automatic tx_send(input logic [20:0] f, input bit junk);
    int t = 0;
    @(negedge clk);
    while (!tx_frame_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_before_send", tx_frame_ready, 1'b1);
    for (int i = 0; i < 4; i++) tx_q.push_back(model_byte(f, i));
    @(posedge clk); #1 tx_frame_in = f; tx_frame_valid = 1'b1;
    @(posedge clk); #1 tx_frame_valid = 1'b0;
    if (junk) begin
      // Mid-frame pulse that must be dropped, not queued.
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 tx_frame_in = 21'($urandom); tx_frame_valid = 1'b1;
      @(posedge clk); #1 tx_frame_valid = 1'b0;
    end
  endtask

  task automatic wait_tx_done();
    int t = 0;
    @(negedge clk);
    while ((tx_q.size() != 0 || !tx_frame_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("tx_done_ready", tx_frame_ready, 1'b1);
    check("tx_bytes_drained", tx_q.size(), 0);
  endtask

  // Receiver model: ready stays up until acknowledged and for at least 'hold' cycles.
  task automatic rx_send_byte(input logic [7:0] b);
    int t, hold;
    bit seen;
    hold = $urandom_range(1, 4);
    seen = 1'b0;
    t    = 0;
    @(posedge clk); #1 rx_uart_data_out = b; rx_uart_ready = 1'b1;
    while ((!seen || t < hold) && t < 400) begin
      @(negedge clk);
      t++;
      if (rx_uart_ready_clr) seen = 1'b1;
    end
    check("rx_byte_acked", seen, 1'b1);
    @(posedge clk); #1 rx_uart_ready = 1'b0;
    rx_bytes_sent++;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic rx_send_pair(input logic [7:0] data, input logic [7:0] flags);
    rx_q.push_back(data);
    rx_send_byte(data);
    rx_send_byte(flags);
  endtask

  task automatic wait_rx_done();
    int t = 0;
    @(negedge clk);
    while (rx_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rx_frames_delivered", rx_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_ready"}, tx_frame_ready, 1'b1);
    check({tag, "_tx_wr_en"}, tx_uart_wr_en, 1'b0);
    check({tag, "_tx_data"}, tx_uart_data_in, 8'h00);
    check({tag, "_rx_clr"}, rx_uart_ready_clr, 1'b0);
    check({tag, "_rx_out"}, rx_frame_out, 8'h00);
    check({tag, "_rx_valid"}, rx_frame_valid, 1'b0);
  endtask

  initial begin
    int cnt, t;
    rstn = 1'b0;
    tx_frame_in = '0; tx_frame_valid = 1'b0;
    rx_uart_data_out = 8'h00; rx_uart_ready = 1'b0; rx_frame_ready = 1'b1;
    busy_force = 1'b0; busy_fixed = 0; rx_done = 1'b0;

    // Model pinned against hand-computed byte sequences.
    check("model_w0", model_byte(21'h1123AA, 0), 8'hAA);
    check("model_w1", model_byte(21'h1123AA, 1), 8'h23);
    check("model_w2", model_byte(21'h1123AA, 2), 8'h01);
    check("model_w3", model_byte(21'h1123AA, 3), 8'h01);
    check("model_r2", model_byte(21'h045600, 2), 8'h04);
    check("model_r3", model_byte(21'h045600, 3), 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // TX write with a slow transmitter; exact first-strobe latency.
    busy_fixed = 100;
    tx_send(21'h1123AA, 1'b0);
    @(negedge clk); check("tx_ready_drop", tx_frame_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("tx_first_strobe", tx_uart_wr_en, 1'b1);
    check("tx_first_byte_lit", tx_uart_data_in, 8'hAA);
    wait_tx_done();
    check("tx_data_held_idle", tx_uart_data_in, 8'h01);

    // TX read.
    busy_fixed = 3;
    tx_send(21'h045600, 1'b0);
    wait_tx_done();

    // RX read response: BB held two cycles, gap, 00 held two cycles.
    rx_q.push_back(8'hBB);
    @(posedge clk); #1 rx_uart_data_out = 8'hBB; rx_uart_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); check("rx_clr_b0", rx_uart_ready_clr, 1'b1);
    @(posedge clk); #1 rx_uart_ready = 1'b0;
    @(negedge clk); check("rx_clr_b0_single", rx_uart_ready_clr, 1'b0);
    repeat (3) @(posedge clk);
    #1 rx_uart_data_out = 8'h00; rx_uart_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); check("rx_clr_b1", rx_uart_ready_clr, 1'b1);
    @(posedge clk); #1 rx_uart_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rx_valid_rise", rx_frame_valid, 1'b1);
    check("rx_out_bb", rx_frame_out, 8'hBB);
    @(negedge clk);
    check("rx_valid_one_cycle", rx_frame_valid, 1'b0);
    check("rx_out_retained", rx_frame_out, 8'hBB);
    rx_bytes_sent += 2;

    // RX write ack.
    rx_send_pair(8'hCC, 8'h01);
    wait_rx_done();
    check("rx_out_cc", rx_frame_out, 8'hCC);

    // RX backpressure.
    rx_frame_ready = 1'b0;
    rx_send_pair(8'hDD, 8'h01);
    t = 0;
    while (!rx_frame_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rx_bp_valid", rx_frame_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rx_bp_hold", rx_frame_valid, 1'b1);
    end
    @(posedge clk); #1 rx_frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); check("rx_bp_clear", rx_frame_valid, 1'b0);

    // Transmitter busy at accept: no strobe until it falls.
    @(posedge clk); #1 busy_force = 1'b1;
    tx_send(21'h1ABCDE, 1'b0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_uart_wr_en) cnt++;
    end
    check("busy_no_strobe", cnt, 0);
    @(posedge clk); #1 busy_force = 1'b0;
    @(posedge clk);
    @(negedge clk); check("busy_release_strobe", tx_uart_wr_en, 1'b1);
    wait_tx_done();

    // Reset in the middle of both paths.
    rx_send_byte(8'h5A);
    tx_send(21'h0F0F0F, 1'b0);
    t = 0;
    while (tx_q.size() > 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reset_pre_strobe", tx_q.size(), 3);
    @(posedge clk); #3 rstn = 1'b0;
    #1 check_reset_values("midreset");
    tx_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    rx_send_pair(8'hEE, 8'h01);
    wait_rx_done();
    check("rx_after_reset", rx_frame_out, 8'hEE);
    tx_send(21'h1FEDCB, 1'b0);
    wait_tx_done();

    // Randomized concurrent traffic.
    busy_fixed = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) tx_send(21'($urandom), ($urandom_range(0, 9) < 3));
        wait_tx_done();
      end
      begin
        for (int i = 0; i < 15; i++) rx_send_pair(8'($urandom), 8'($urandom));
        wait_rx_done();
        rx_done = 1'b1;
      end
      begin
        while (!rx_done) begin
          @(posedge clk); #1 rx_frame_ready = ($urandom_range(0, 1) == 1);
        end
        rx_frame_ready = 1'b1;
      end
    join

    repeat (4) @(posedge clk);
    check("rx_clr_count", n_clr, rx_bytes_sent);
    check("final_tx_queue", tx_q.size(), 0);
    check("final_rx_queue", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
